// File: rtl/ddr_sim_mem.sv
// Cycle-approximate DDR model behind the sim_ram arbiter: one request at a time,
// 64-bit word array, single-word loads, 512-bit burst line reads, programmable latency.
module ddr_sim_mem #(
   parameter int INDEX_W   = 19,
   parameter int MEM_WORDS = 4096,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2,
   parameter int BURST_LEN = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      ddr_chip_enable,
   input  logic [INDEX_W-1:0]        ddr_index,
   input  logic                      ddr_write_enable,
   input  logic                      ddr_burst_mode,
   input  logic [63:0]               ddr_opstore_write_mask,
   input  logic [63:0]               ddr_opstore_write_data,
   output logic [63:0]               ddr_opload_read_data,
   output logic [BURST_LEN*64-1:0]   ddr_pc_read_inst,
   output logic                      ddr_operation_done,
   output logic                      ddr_ready
);

   localparam int ADDR_W  = $clog2(MEM_WORDS);
   localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_MAX = (LAT_MAX > BURST_LEN) ? LAT_MAX : BURST_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

   state_t                   state, state_next;
   logic [CNT_W-1:0]         count, count_next;
   logic [63:0]              mem [MEM_WORDS];
   logic [ADDR_W-1:0]        word_addr, burst_base, accept_addr, req_addr, beat_addr;
   logic                     req_write, req_burst;
   logic [BURST_LEN*64-1:0]  line_buf, line_next;
   logic                     load_single, capture_beat, load_line;

   // Index bits above the array size alias; bursts are line-aligned before aliasing.
   assign word_addr   = ADDR_W'(ddr_index);
   assign burst_base  = ADDR_W'({ddr_index[INDEX_W-1:3], 3'b000});
   assign accept_addr = (ddr_burst_mode && !ddr_write_enable) ? burst_base : word_addr;
   assign beat_addr   = req_addr + ADDR_W'(count);

   always_ff @(posedge clock) begin
      if (ddr_chip_enable && ddr_write_enable)
         mem[word_addr] <= (mem[word_addr] & ~ddr_opstore_write_mask) |
                           (ddr_opstore_write_data & ddr_opstore_write_mask);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // A new accept always wins, aborting whatever WAIT/BURST was in flight.
   always_comb begin
      state_next   = state;
      count_next   = count;
      load_single  = 1'b0;
      capture_beat = 1'b0;
      load_line    = 1'b0;
      line_next    = line_buf;
      line_next[64*int'(count) +: 64] = mem[beat_addr];
      ddr_ready          = (state == IDLE) || (state == DONE);
      ddr_operation_done = (state == DONE);
      if (ddr_chip_enable) begin
         state_next = WAIT;
         count_next = ddr_write_enable ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            WAIT: begin
               if (count == '0) begin
                  if (req_burst) begin
                     state_next = BURST;
                     count_next = '0;
                  end else begin
                     state_next  = DONE;
                     load_single = !req_write;
                  end
               end else begin
                  count_next = count - CNT_W'(1);
               end
            end
            BURST: begin
               capture_beat = 1'b1;
               if (count == CNT_W'(BURST_LEN - 1)) begin
                  state_next = DONE;
                  load_line  = 1'b1;
               end else begin
                  count_next = count + CNT_W'(1);
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_addr             <= '0;
         req_write            <= 1'b0;
         req_burst            <= 1'b0;
         line_buf             <= '0;
         ddr_opload_read_data <= '0;
         ddr_pc_read_inst     <= '0;
      end else begin
         if (ddr_chip_enable) begin
            req_addr  <= accept_addr;
            req_write <= ddr_write_enable;
            req_burst <= ddr_burst_mode && !ddr_write_enable;
         end
         if (load_single)
            ddr_opload_read_data <= mem[req_addr];
         if (capture_beat)
            line_buf <= line_next;
         if (load_line)
            ddr_pc_read_inst <= line_next;
      end
   end

endmodule

// File: tb/tb_ddr_sim_mem.sv
// Self-checking bench for ddr_sim_mem: directed vector table, hand-written corner
// sequences and random traffic, all compared per cycle against a request-level model.
module tb_ddr_sim_mem;

   localparam int INDEX_W   = 19;
   localparam int MEM_WORDS = 4096;
   localparam int READ_LAT  = 4;
   localparam int WRITE_LAT = 2;
   localparam int BURST_LEN = 8;

   logic                 clock = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 ddr_chip_enable = 1'b0;
   logic [INDEX_W-1:0]   ddr_index = '0;
   logic                 ddr_write_enable = 1'b0;
   logic                 ddr_burst_mode = 1'b0;
   logic [63:0]          ddr_opstore_write_mask = '0;
   logic [63:0]          ddr_opstore_write_data = '0;
   logic [63:0]          ddr_opload_read_data;
   logic [511:0]         ddr_pc_read_inst;
   logic                 ddr_operation_done;
   logic                 ddr_ready;

   always #5 clock = ~clock;

   ddr_sim_mem #(
      .INDEX_W(INDEX_W), .MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT),
      .WRITE_LAT(WRITE_LAT), .BURST_LEN(BURST_LEN)
   ) dut (
      .clock(clock), .reset_n(reset_n), .ddr_chip_enable(ddr_chip_enable),
      .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable),
      .ddr_burst_mode(ddr_burst_mode), .ddr_opstore_write_mask(ddr_opstore_write_mask),
      .ddr_opstore_write_data(ddr_opstore_write_data),
      .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
      .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready)
   );

   int unsigned checks = 0, errors = 0, edge_n = 0, acc_edge = 0;

   // Request-level model: one pending request with a due edge; outputs latch at completion.
   logic [63:0]  mm [MEM_WORDS];
   bit           pend = 0, p_we = 0, p_bu = 0, exp_done = 0;
   int unsigned  p_edge = 0, p_lat = 0, p_idx = 0;
   logic [63:0]  exp_load = '0;
   logic [511:0] exp_line = '0;

   typedef struct {
      bit          we;
      bit          bu;
      int unsigned idx;
      logic [63:0] mk;
      logic [63:0] dt;
      int unsigned lat;
      bit          chk;
      logic [63:0] rd;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic model_edge(input bit ce, input bit we, input bit bu, input int unsigned idx,
                             input logic [63:0] mk, input logic [63:0] dt);
      exp_done = 0;
      if (ce) begin
         if (we) mm[idx % MEM_WORDS] = (mm[idx % MEM_WORDS] & ~mk) | (dt & mk);
         pend   = 1;
         p_we   = we;
         p_bu   = bu && !we;
         p_idx  = idx;
         p_edge = edge_n;
         p_lat  = we ? WRITE_LAT : (bu ? READ_LAT + BURST_LEN : READ_LAT);
      end
      if (pend && edge_n == p_edge + p_lat) begin
         exp_done = 1;
         pend     = 0;
         if (!p_we) begin
            if (p_bu)
               for (int k = 0; k < BURST_LEN; k++)
                  exp_line[64*k +: 64] = mm[((p_idx / 8) * 8 + k) % MEM_WORDS];
            else
               exp_load = mm[p_idx % MEM_WORDS];
         end
      end
   endtask

   task automatic model_reset();
      pend = 0; exp_done = 0; exp_load = '0; exp_line = '0;
   endtask

   task automatic cycle(input bit ce, input bit we, input bit bu, input int unsigned idx,
                        input logic [63:0] mk, input logic [63:0] dt);
      ddr_chip_enable        = ce;
      ddr_write_enable       = we;
      ddr_burst_mode         = bu;
      ddr_index              = INDEX_W'(idx);
      ddr_opstore_write_mask = mk;
      ddr_opstore_write_data = dt;
      @(posedge clock);
      edge_n++;
      model_edge(ce, we, bu, idx, mk, dt);
      #1;
      ddr_chip_enable = 1'b0;
      check("done",  512'(ddr_operation_done),   512'(exp_done));
      check("ready", 512'(ddr_ready),            512'(!pend));
      check("load",  512'(ddr_opload_read_data), 512'(exp_load));
      check("line",  ddr_pc_read_inst,           exp_line);
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) cycle(0, 0, 0, 0, '0, '0);
   endtask

   task automatic request(input bit we, input bit bu, input int unsigned idx,
                          input logic [63:0] mk, input logic [63:0] dt);
      cycle(1, we, bu, idx, mk, dt);
      acc_edge = edge_n;
   endtask

   task automatic wait_done(output int unsigned lat);
      int unsigned n;
      n = 0;
      lat = 0;
      while (ddr_operation_done !== 1'b1 && n < 64) begin
         idle(1);
         n++;
      end
      if (ddr_operation_done === 1'b1) begin
         lat = edge_n - acc_edge;
         check("ready_at_done", 512'(ddr_ready), 512'(1));
      end else begin
         check("done_timeout", 512'(ddr_operation_done), 512'(1));
      end
   endtask

   task automatic write_word(input int unsigned idx, input logic [63:0] dt);
      int unsigned lat;
      request(1, 0, idx, 64'hFFFF_FFFF_FFFF_FFFF, dt);
      wait_done(lat);
   endtask

   function automatic int unsigned pick_idx();
      case ($urandom_range(3))
         0:       return 4088 + $urandom_range(7);
         1:       return MEM_WORDS + $urandom_range(63);
         default: return $urandom_range(63);
      endcase
   endfunction

   initial begin
      int unsigned lat;
      bit          r_we, r_bu;
      int unsigned r_idx;

      tbl[0] = '{we:1, bu:0, idx:5,  mk:64'hFFFF_FFFF_FFFF_FFFF, dt:64'hDEAD_BEEF_0123_4567, lat:2, chk:0, rd:64'h0};
      tbl[1] = '{we:0, bu:0, idx:5,  mk:64'h0, dt:64'h0, lat:4, chk:1, rd:64'hDEAD_BEEF_0123_4567};
      tbl[2] = '{we:1, bu:0, idx:7,  mk:64'hFFFF_FFFF_FFFF_FFFF, dt:64'hFFFF_FFFF_FFFF_FFFF, lat:2, chk:0, rd:64'h0};
      tbl[3] = '{we:1, bu:0, idx:7,  mk:64'h0000_0000_FFFF_0000, dt:64'h0, lat:2, chk:0, rd:64'h0};
      tbl[4] = '{we:0, bu:0, idx:7,  mk:64'h0, dt:64'h0, lat:4, chk:1, rd:64'hFFFF_FFFF_0000_FFFF};
      tbl[5] = '{we:1, bu:1, idx:9,  mk:64'hFFFF_FFFF_FFFF_FFFF, dt:64'h55, lat:2, chk:0, rd:64'h0};
      tbl[6] = '{we:0, bu:0, idx:9,  mk:64'h0, dt:64'h0, lat:4, chk:1, rd:64'h55};
      tbl[7] = '{we:0, bu:0, idx:MEM_WORDS + 5, mk:64'h0, dt:64'h0, lat:4, chk:1, rd:64'hDEAD_BEEF_0123_4567};

      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", 512'(ddr_ready),            512'(1));
      check("rst_done",  512'(ddr_operation_done),   512'(0));
      check("rst_load",  512'(ddr_opload_read_data), 512'(0));
      check("rst_line",  ddr_pc_read_inst,           512'(0));
      @(negedge clock) reset_n = 1'b1;

      for (int i = 0; i < 64; i++) write_word(i, {$urandom, $urandom});
      for (int i = 4088; i < 4096; i++) write_word(i, {$urandom, $urandom});
      for (int k = 0; k < 8; k++) write_word(16 + k, 64'h100 + 64'(k));

      // Rows issue back-to-back: each request is accepted in the previous row's done cycle.
      for (int i = 0; i < 8; i++) begin
         request(tbl[i].we, tbl[i].bu, tbl[i].idx, tbl[i].mk, tbl[i].dt);
         wait_done(lat);
         check("tbl_lat", 512'(lat), 512'(tbl[i].lat));
         if (tbl[i].chk) check("tbl_data", 512'(ddr_opload_read_data), 512'(tbl[i].rd));
      end
      idle(2);

      request(0, 1, 19, '0, '0);
      wait_done(lat);
      check("burst_lat",   512'(lat), 512'(READ_LAT + BURST_LEN));
      check("burst_beat0", 512'(ddr_pc_read_inst[63:0]),    512'(64'h100));
      check("burst_beat7", 512'(ddr_pc_read_inst[511:448]), 512'(64'h107));

      request(0, 0, 5, '0, '0);
      wait_done(lat);
      request(0, 0, 7, '0, '0);
      check("b2b_busy", 512'(ddr_ready), 512'(0));
      wait_done(lat);
      check("b2b_lat",  512'(lat), 512'(READ_LAT));
      check("b2b_data", 512'(ddr_opload_read_data), 512'(64'hFFFF_FFFF_0000_FFFF));
      idle(2);

      request(0, 1, 16, '0, '0);
      idle(2);
      request(0, 1, 32, '0, '0);
      wait_done(lat);
      check("redir_lat",   512'(lat), 512'(READ_LAT + BURST_LEN));
      check("redir_beat0", 512'(ddr_pc_read_inst[63:0]), 512'(mm[32]));
      idle(4);

      request(0, 1, MEM_WORDS - 4, '0, '0);
      wait_done(lat);
      check("hi_lat",   512'(lat), 512'(READ_LAT + BURST_LEN));
      check("hi_beat7", 512'(ddr_pc_read_inst[511:448]), 512'(mm[MEM_WORDS - 1]));
      request(0, 1, MEM_WORDS + 3, '0, '0);
      wait_done(lat);
      check("alias_beat0", 512'(ddr_pc_read_inst[63:0]), 512'(mm[0]));
      idle(2);

      request(0, 0, 5, '0, '0);
      idle(1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("arst_ready", 512'(ddr_ready),            512'(1));
      check("arst_done",  512'(ddr_operation_done),   512'(0));
      check("arst_load",  512'(ddr_opload_read_data), 512'(0));
      @(negedge clock) reset_n = 1'b1;
      idle(8);

      request(1, 0, 40, 64'hFFFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_1234_5678);
      reset_n = 1'b0;
      model_reset();
      @(negedge clock) reset_n = 1'b1;
      idle(3);
      request(0, 0, 40, '0, '0);
      wait_done(lat);
      check("persist", 512'(ddr_opload_read_data), 512'(64'hCAFE_F00D_1234_5678));

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(3) == 0) begin
            r_we  = 1'($urandom_range(1));
            r_bu  = 1'($urandom_range(1));
            r_idx = pick_idx();
            cycle(1, r_we, r_bu, r_idx, {$urandom, $urandom}, {$urandom, $urandom});
         end else begin
            idle(1);
         end
      end
      idle(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
